fmc_spi_sched: RTL
==================

Name: fmc_spi_sched

Overview:
- Transaction scheduler in front of the FMC-200A SPI configuration master engine.
- After reset it runs the fixed Camera Link base-mode boot sequence.
- It then shares the engine among NUM_REQ runtime requesters (host register writes, readback, calibration) using round-robin arbitration.
- It enforces a minimum SS-high gap between transactions and a completion watchdog; it sits between the control-plane requesters and the engine in the 500 MHz domain.

Parameters:
- NUM_REQ, 3, number of runtime requesters (1..8).
- GAP_CYC, 26, minimum idle i_clk cycles between engine done and the next engine start.
- TIMEOUT_CYC, 1024, i_clk cycles allowed from engine start to i_eng_done.
- BOOT_LEN, 4, number of boot ROM words.

Ports:
- i_clk  in  1  system clock, 500 MHz
- i_rst_n  in  1  reset
- i_init_en  in  1  level; boot sequence starts while high in IDLE
- i_req_valid  in  NUM_REQ  per-requester request; held until accepted
- i_req_cmd  in  NUM_REQ*16  per-requester 16-bit {addr[7:0], data[7:0]}; requester r at bits [16r+15:16r]
- o_req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
- o_rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot, to the granted requester
- o_rsp_data  out  16  captured i_eng_rdata; valid with o_rsp_valid
- o_rsp_err  out  1  with o_rsp_valid; 1 = transaction timed out
- o_eng_start  out  1  one-cycle start pulse to the SPI engine
- o_eng_cmd  out  16  command word; stable from start until done or timeout
- i_eng_done  in  1  one-cycle pulse from the engine at end of transaction
- i_eng_rdata  in  16  MISO shift data, valid with i_eng_done
- o_boot_done  out  1  sticky; boot sequence complete
- o_busy  out  1  high in any state except IDLE and ARB-with-no-request
- o_timeout  out  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Reset: i_rst_n, synchronous, active-low; clock i_clk. All outputs reset to 0. State = IDLE, RR pointer = NUM_REQ-1 (first grant goes to requester 0), boot index = 0.
- All outputs are registered.
- States:
  - IDLE → BOOT_ISSUE when i_init_en=1.
  - BOOT_ISSUE: o_eng_start=1 for one cycle, o_eng_cmd=rom[idx] → BOOT_WAIT.
  - BOOT_WAIT: on i_eng_done → GAP, idx+1.
  - GAP: counts GAP_CYC cycles. Then → BOOT_ISSUE if idx<BOOT_LEN; otherwise set o_boot_done and → ARB.
  - ARB: if any i_req_valid, pick the first valid index searching from ptr+1 mod NUM_REQ. Next cycle: o_req_ready[g]=1, o_eng_start=1, o_eng_cmd=i_req_cmd[g], ptr=g → RUN_WAIT.
  - RUN_WAIT: on i_eng_done, next cycle o_rsp_valid[g]=1, o_rsp_data=i_eng_rdata, o_rsp_err=0 → GAP.
- Boot ROM: 0x0003, 0x1530, 0x0605, 0x0900, in that order.
- Runtime requests are never granted before o_boot_done=1.
- Watchdog: counter cleared at every o_eng_start and increments in BOOT_WAIT/RUN_WAIT.
  - At TIMEOUT_CYC it sets o_timeout and treats the transaction as done.
  - Runtime transaction: o_rsp_valid[g]=1, o_rsp_err=1, o_rsp_data=0.
  - Boot transaction: the word is skipped and the sequence continues.
  - Both cases → GAP.
- If i_eng_done and the timeout expire in the same cycle, done wins: o_rsp_err=0, o_timeout unchanged.
- i_eng_done outside BOOT_WAIT/RUN_WAIT is ignored.
- i_init_en is ignored outside IDLE; deasserting it mid-boot does not abort the sequence.
- A request deasserted before grant is simply not granted. There is no queueing, and at most one transaction is in flight.
- Reset mid-transaction: outputs return to 0 the next cycle; in-flight state is abandoned and the engine's own reset is relied on.
- RR pointer wrap: NUM_REQ-1 → 0. With a single valid requester, it is granted back-to-back, separated only by GAP.
- Counter widths: $clog2(max(GAP_CYC,TIMEOUT_CYC)+1).

Decomposition:
- Shared package fmc_cfg_pkg holds:
  - boot ROM words as a localparam array;
  - BOOT_LEN;
  - the sched_state_t enum (IDLE, BOOT_ISSUE, BOOT_WAIT, ARB, RUN_WAIT, GAP);
  - the command field layout constants.
- One sub-module: fmc_rr_arbiter.
  - Inputs: request vector, pointer.
  - Outputs: grant index, any-valid flag.
  - Combinational, so the round-robin logic is reusable and unit-testable.

Test Plan:
- Boot: reset, i_init_en=1, engine model completes in 400 cycles → o_eng_cmd sequence 0x0003, 0x1530, 0x0605, 0x0900. o_boot_done rises one cycle after the 4th GAP. Start-to-start spacing ≥ 400+GAP_CYC.
- Pre-boot block: i_req_valid=3'b001 held from reset with i_init_en=0 for 1000 cycles → no o_req_ready, no o_eng_start.
- Round-robin: after boot, all three valid continuously with cmds 0xA1xx/0xB2xx/0xC3xx → grants in order 0,1,2,0. Each o_req_ready is coincident with o_eng_start, and o_rsp_valid one-hot matches the grant.
- Readback: grant requester 1, i_eng_done with i_eng_rdata=0x5A5A → next cycle o_rsp_valid=3'b010, o_rsp_data=0x5A5A, o_rsp_err=0.
- Timeout: engine never responds → o_rsp_err=1, o_rsp_data=0, o_timeout=1 at TIMEOUT_CYC after the start. A following request is still serviced. Done on the exact timeout cycle → o_rsp_err=0.
- Reset mid-RUN_WAIT → all outputs 0 the next cycle, o_boot_done=0. Reboot with i_init_en restarts from word 0x0003.

Source files
------------

// File: rtl/fmc_cfg_pkg.sv
// Shared definitions for the FMC-200A SPI configuration path: command layout,
// the fixed Camera Link base-mode boot ROM and the scheduler state encoding.
package fmc_cfg_pkg;

    localparam int CMD_W        = 16;
    localparam int CMD_FIELD_W  = 8;
    localparam int CMD_ADDR_LSB = 8;
    localparam int CMD_DATA_LSB = 0;

    typedef struct packed {
        logic [CMD_FIELD_W-1:0] addr;
        logic [CMD_FIELD_W-1:0] data;
    } spi_cmd_t;

    localparam int BOOT_LEN = 4;
    localparam logic [CMD_W-1:0] BOOT_ROM [BOOT_LEN] = '{16'h0003, 16'h1530, 16'h0605, 16'h0900};

    typedef enum logic [2:0] {
        IDLE,
        BOOT_ISSUE,
        BOOT_WAIT,
        ARB,
        RUN_WAIT,
        GAP
    } sched_state_t;

endpackage

// File: rtl/fmc_rr_arbiter.sv
// Round-robin pick: first asserted request searching upward from ptr+1, wrapping.
// Purely combinational (zero latency); no backpressure, caller samples the result.
module fmc_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [PW-1:0]      gnt,
    output logic               any_vld
);

    logic [PW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        gnt     = '0;
        any_vld = 1'b0;
        idx     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                gnt     = idx;
                any_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmc_spi_sched.sv
// Boots the FMC-200A via its SPI engine, then round-robins runtime requesters onto it.
// Grant/start one cycle after ARB, response one cycle after done; requesters hold valid until ready.
module fmc_spi_sched
    import fmc_cfg_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int GAP_CYC     = 26,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_init_en,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*CMD_W-1:0] i_req_cmd,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic [NUM_REQ-1:0]       o_rsp_valid,
    output logic [15:0]              o_rsp_data,
    output logic                     o_rsp_err,
    output logic                     o_eng_start,
    output logic [CMD_W-1:0]         o_eng_cmd,
    input  logic                     i_eng_done,
    input  logic [15:0]              i_eng_rdata,
    output logic                     o_boot_done,
    output logic                     o_busy,
    output logic                     o_timeout
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(((GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC) + 1);
    localparam int IW = $clog2(BOOT_LEN + 1);
    localparam int RW = (BOOT_LEN > 1) ? $clog2(BOOT_LEN) : 1;

    sched_state_t  state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt;
    logic [PW-1:0] arb_gnt;
    logic          arb_any;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          tmo_hit;
    spi_cmd_t      req_cmd [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_cmd
        assign req_cmd[r] = i_req_cmd[r*CMD_W +: CMD_W];
    end

    fmc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .req     (i_req_valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .any_vld (arb_any)
    );

    // One counter serves both the watchdog and the SS-high gap; they never overlap.
    assign tmo_hit = (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            ptr         <= PW'(NUM_REQ - 1);
            gnt         <= '0;
            cnt         <= '0;
            idx         <= '0;
            o_req_ready <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
            o_eng_start <= 1'b0;
            o_eng_cmd   <= '0;
            o_boot_done <= 1'b0;
            o_busy      <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_req_ready <= '0;
            o_rsp_valid <= '0;
            o_eng_start <= 1'b0;
            o_busy      <= 1'b1;
            case (state)
                IDLE: begin
                    o_busy <= i_init_en;
                    if (i_init_en) state <= BOOT_ISSUE;
                end
                BOOT_ISSUE: begin
                    o_eng_start <= 1'b1;
                    o_eng_cmd   <= BOOT_ROM[idx[RW-1:0]];
                    cnt         <= '0;
                    state       <= BOOT_WAIT;
                end
                BOOT_WAIT: begin
                    // A timed-out boot word is dropped and the sequence moves on.
                    if (i_eng_done || tmo_hit) begin
                        if (!i_eng_done) o_timeout <= 1'b1;
                        idx   <= idx + 1'b1;
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CW'(GAP_CYC - 1)) begin
                        cnt <= '0;
                        if (idx < IW'(BOOT_LEN)) begin
                            state <= BOOT_ISSUE;
                        end else begin
                            o_boot_done <= 1'b1;
                            o_busy      <= arb_any;
                            state       <= ARB;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARB: begin
                    o_busy <= arb_any;
                    if (arb_any) begin
                        o_req_ready[arb_gnt] <= 1'b1;
                        o_eng_start          <= 1'b1;
                        o_eng_cmd            <= req_cmd[arb_gnt];
                        ptr                  <= arb_gnt;
                        gnt                  <= arb_gnt;
                        cnt                  <= '0;
                        state                <= RUN_WAIT;
                    end
                end
                RUN_WAIT: begin
                    // Done takes priority over a watchdog expiry in the same cycle.
                    if (i_eng_done || tmo_hit) begin
                        o_rsp_valid[gnt] <= 1'b1;
                        o_rsp_err        <= !i_eng_done;
                        o_rsp_data       <= i_eng_done ? i_eng_rdata : 16'h0;
                        if (!i_eng_done) o_timeout <= 1'b1;
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
